// File: rtl/channel_mixer_if.sv
// Shared types and the bus bundle between the operator sequencer and the channel mixer.
// The master side drives operator outputs and register writes; the slave mixes them.
package channel_mixer_pkg;
  localparam int OP_NUM_WIDTH = 5;
  localparam int OP_OUT_WIDTH = 13;

  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;

  typedef struct packed {
    logic                    valid;
    logic [OP_NUM_WIDTH-1:0] op_num;
    logic [OP_OUT_WIDTH-1:0] op_out;   // two's complement operator output
  } operator_out_t;
endpackage

interface channel_mixer_if #(
  parameter int DAC_OUTPUT_WIDTH = 16
);
  import channel_mixer_pkg::*;

  opl2_reg_wr_t                        opl2_reg_wr;
  logic                                ryt;
  operator_out_t                       operator_out;
  logic signed [DAC_OUTPUT_WIDTH-1:0]  sample;
  logic                                sample_valid;
  logic                                frame_error;

  modport master (
    output opl2_reg_wr, ryt, operator_out,
    input  sample, sample_valid, frame_error
  );

  modport slave (
    input  opl2_reg_wr, ryt, operator_out,
    output sample, sample_valid, frame_error
  );
endinterface

// File: rtl/channel_mixer.sv
// Mixes the 18 serial operator outputs of one sample period into a saturated DAC sample
// through a decode / accumulate / output pipeline (three cycles from op 17 to the strobe).
module channel_mixer #(
  parameter int OP_OUT_WIDTH     = channel_mixer_pkg::OP_OUT_WIDTH,
  parameter int DAC_OUTPUT_WIDTH = 16,
  parameter int GAIN_SHIFT       = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  channel_mixer_if.slave  bus
);
  localparam int ACC_W = OP_OUT_WIDTH + 6;
  localparam int SH_W  = ACC_W + GAIN_SHIFT;
  localparam logic signed [SH_W-1:0] DAC_MAX = SH_W'((2 ** (DAC_OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [SH_W-1:0] DAC_MIN = -DAC_MAX - SH_W'(1);

  logic [8:0]               cnt_q;
  logic [7:0]               wr_idx;
  logic [4:0]               op_num;
  logic [4:0]               grp;
  logic [3:0]               ch;
  logic signed [ACC_W-1:0]  op_ext;
  logic signed [ACC_W-1:0]  contrib_d;

  logic                     a_valid_q, a_first_q, a_last_q;
  logic signed [ACC_W-1:0]  a_contrib_q;

  logic signed [ACC_W-1:0]  acc_q;
  logic [4:0]               count_q;
  logic                     armed_q, b_last_q, b_ok_q;

  logic signed [SH_W-1:0]             shifted;
  logic signed [DAC_OUTPUT_WIDTH-1:0] sat_val;
  logic signed [DAC_OUTPUT_WIDTH-1:0] sample_q;
  logic                               sample_valid_q, frame_error_q;
  logic                               unused_bits;

  assign wr_idx      = bus.opl2_reg_wr.address - 8'hC0;
  assign op_num      = bus.operator_out.op_num;
  assign unused_bits = ^{wr_idx[7:4], bus.opl2_reg_wr.data[7:1]};

  // Operator n belongs to channel (n/6)*3 + n%3; slots 3..5 of each group of six are carriers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    contrib_d = '0;
    grp       = op_num % 5'd6;
    ch        = 4'((op_num / 5'd6) * 5'd3 + op_num % 5'd3);
    op_ext    = ACC_W'($signed(bus.operator_out.op_out));
    if (op_num > 5'd17) begin
      contrib_d = '0;
    end else if (bus.ryt && op_num >= 5'd12) begin
      if (op_num != 5'd12 || cnt_q[6]) contrib_d = op_ext <<< 1;
    end else if (grp >= 5'd3 || cnt_q[ch]) begin
      contrib_d = op_ext;
    end
  end

  // Pre-shift at ACC_W+GAIN_SHIFT bits so the clamp sees the true value.
  always_comb begin
    shifted = SH_W'(acc_q) <<< GAIN_SHIFT;
    sat_val = shifted[DAC_OUTPUT_WIDTH-1:0];
    if (shifted > DAC_MAX)      sat_val = DAC_MAX[DAC_OUTPUT_WIDTH-1:0];
    else if (shifted < DAC_MIN) sat_val = DAC_MIN[DAC_OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      a_valid_q      <= 1'b0;
      a_first_q      <= 1'b0;
      a_last_q       <= 1'b0;
      a_contrib_q    <= '0;
      acc_q          <= '0;
      count_q        <= '0;
      armed_q        <= 1'b0;
      b_last_q       <= 1'b0;
      b_ok_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let stage A use the pre-write cnt in the same cycle.
      if (bus.opl2_reg_wr.valid && bus.opl2_reg_wr.address >= 8'hC0 &&
          bus.opl2_reg_wr.address <= 8'hC8) begin
        cnt_q[wr_idx[3:0]] <= bus.opl2_reg_wr.data[0];
      end

      a_valid_q   <= bus.operator_out.valid;
      a_first_q   <= (op_num == 5'd0);
      a_last_q    <= (op_num == 5'd17);
      a_contrib_q <= contrib_d;

      b_last_q <= 1'b0;
      b_ok_q   <= 1'b0;
      if (a_valid_q) begin
        if (a_first_q) begin
          acc_q   <= a_contrib_q;
          count_q <= 5'd1;
          armed_q <= 1'b1;
        end else begin
          acc_q   <= acc_q + a_contrib_q;
          count_q <= (count_q == 5'd31) ? count_q : count_q + 5'd1;
          if (a_last_q) begin
            // count_q of 17 here becomes 18 with this operator: a complete frame.
            b_last_q <= 1'b1;
            b_ok_q   <= armed_q && (count_q == 5'd17);
            armed_q  <= 1'b0;
          end
        end
      end

      sample_valid_q <= b_last_q && b_ok_q;
      frame_error_q  <= b_last_q && !b_ok_q;
      if (b_last_q && b_ok_q) sample_q <= sat_val;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_error  = frame_error_q;
endmodule

// File: tb/tb_channel_mixer.sv
// Self-checking bench for channel_mixer: directed scenarios plus randomized frames
// against a frame-level reference model; a per-cycle checker enforces strobe timing.
module tb_channel_mixer;
  import channel_mixer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  channel_mixer_if #(.DAC_OUTPUT_WIDTH(16)) bus ();

  channel_mixer #(
    .OP_OUT_WIDTH(13),
    .DAC_OUTPUT_WIDTH(16),
    .GAIN_SHIFT(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int due;
    bit sv;
    bit fe;
    int smp;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  exp_t exp_q[$];
  exp_t e_cur;
  int   hold = 0;
  int   sv_seen = 0;
  int   fe_seen = 0;

  // Reference model state
  logic [8:0] m_cnt = '0;
  int         m_acc = 0;
  int         m_count = 0;
  bit         m_armed = 0;
  int         m_last = 0;

  always @(posedge clk) cyc++;

  // Every cycle: a due expectation must appear exactly now, otherwise outputs stay quiet and sample holds.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.sample_valid === 1'b1) sv_seen++;
      if (bus.frame_error === 1'b1) fe_seen++;
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e_cur = exp_q.pop_front();
        if (bus.sample_valid !== e_cur.sv || bus.frame_error !== e_cur.fe ||
            bus.sample !== 16'(e_cur.smp)) begin
          errors++;
          $display("FAIL strobe cyc=%0d: got sv=%b fe=%b sample=%0d, expected sv=%b fe=%b sample=%0d",
                   cyc, bus.sample_valid, bus.frame_error, bus.sample, e_cur.sv, e_cur.fe, e_cur.smp);
        end
        hold = e_cur.smp;
      end else if (bus.sample_valid !== 1'b0 || bus.frame_error !== 1'b0 ||
                   bus.sample !== 16'(hold)) begin
        errors++;
        $display("FAIL quiet cyc=%0d: got sv=%b fe=%b sample=%0d, expected sv=0 fe=0 sample=%0d",
                 cyc, bus.sample_valid, bus.frame_error, bus.sample, hold);
      end
    end
  end

  function automatic int ref_contrib(int n, int v, logic [8:0] c, bit r);
    int g;
    int ch;
    if (n > 17) return 0;
    if (r && n >= 13) return 2 * v;
    if (r && n == 12) return c[6] ? 2 * v : 0;
    g  = n % 6;
    ch = (n / 6) * 3 + n % 3;
    if (g >= 3) return v;
    return c[ch] ? v : 0;
  endfunction

  function automatic int sat16(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_op(input int n, input int v);
    exp_t e;
    int c;
    c = ref_contrib(n, v, m_cnt, bus.ryt);
    if (n == 0) begin
      m_acc   = c;
      m_count = 1;
      m_armed = 1;
    end else begin
      m_acc   = m_acc + c;
      m_count = (m_count >= 31) ? 31 : m_count + 1;
      if (n == 17) begin
        e.due = cyc + 3;
        if (m_armed && m_count == 18) begin
          m_last = sat16(m_acc * 2);
          e.sv = 1'b1;
          e.fe = 1'b0;
        end else begin
          e.sv = 1'b0;
          e.fe = 1'b1;
        end
        e.smp = m_last;
        exp_q.push_back(e);
        m_armed = 0;
      end
    end
  endtask

  // One cycle of stimulus; called just after a rising edge.
  task automatic drive(input bit opv, input int n, input int v, input bit wv,
                       input int addr, input int data);
    bus.operator_out.valid  = opv;
    bus.operator_out.op_num = 5'(n);
    bus.operator_out.op_out = 13'(v);
    bus.opl2_reg_wr.valid   = wv;
    bus.opl2_reg_wr.address = 8'(addr);
    bus.opl2_reg_wr.data    = 8'(data);
    if (opv) model_op(n, v);
    if (wv && addr >= 'hC0 && addr <= 'hC8) m_cnt[addr - 'hC0] = data[0];
    @(posedge clk);
    #1;
    bus.operator_out.valid = 1'b0;
    bus.opl2_reg_wr.valid  = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input int addr, input int data);
    drive(1'b0, 0, 0, 1'b1, addr, data);
  endtask

  task automatic send_ops(input int vals[18], input int first, input int last, input int gap);
    for (int n = first; n <= last; n++) begin
      drive(1'b1, n, vals[n], 1'b0, 0, 0);
      idle(gap);
    end
  endtask

  task automatic apply_reset(input int k);
    reset_n = 1'b0;
    m_cnt = '0;
    m_acc = 0;
    m_count = 0;
    m_armed = 0;
    m_last = 0;
    hold = 0;
    exp_q.delete();
    idle(k);
    reset_n = 1'b1;
  endtask

  task automatic expect_sample(input string name, input int want);
    checks++;
    if (bus.sample !== 16'(want)) begin
      errors++;
      $display("FAIL %s: sample=%0d expected %0d", name, bus.sample, want);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    chk_en = 1;
    for (int i = 0; i < 8; i++) begin
      bus.operator_out.valid  = 1'($urandom);
      bus.operator_out.op_num = 5'($urandom_range(17));
      bus.operator_out.op_out = 13'($urandom);
      bus.opl2_reg_wr.valid   = 1'($urandom);
      bus.opl2_reg_wr.address = 8'($urandom_range('hC8, 'hC0));
      bus.opl2_reg_wr.data    = 8'($urandom);
      bus.ryt                 = 1'($urandom);
      @(negedge clk);
      checks += 3;
      if (bus.sample !== 16'sd0) begin
        errors++;
        $display("FAIL reset_sample: got %0d expected 0", bus.sample);
      end
      if (bus.sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_sample_valid: got %b expected 0", bus.sample_valid);
      end
      if (bus.frame_error !== 1'b0) begin
        errors++;
        $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error);
      end
      @(posedge clk);
      #1;
    end
    bus.operator_out.valid = 1'b0;
    bus.opl2_reg_wr.valid  = 1'b0;
    bus.ryt                = 1'b0;
    reset_n = 1'b1;
    idle(20);
  endtask

  task automatic test_basic_carrier();
    int vals[18] = '{default: 0};
    vals[3] = 100;
    send_ops(vals, 0, 17, 1);
    idle(4);
    expect_sample("basic_carrier", 200);
  endtask

  task automatic test_additive();
    int vals[18] = '{default: 0};
    vals[0] = 50;
    vals[3] = 100;
    write_reg('hC0, 'h01);
    send_ops(vals, 0, 17, 1);
    idle(4);
    expect_sample("additive", 300);
    write_reg('hC0, 'h00);
    drive(1'b1, 0, 50, 1'b1, 'hC0, 'h01);
    send_ops(vals, 1, 17, 1);
    idle(4);
    expect_sample("same_cycle_write", 200);
    write_reg('hC0, 'h00);
  endtask

  task automatic test_rhythm();
    int vals[18] = '{default: 0};
    vals[12] = 500;
    vals[13] = 1000;
    vals[14] = 1000;
    vals[16] = 1000;
    vals[17] = 1000;
    bus.ryt = 1'b1;
    write_reg('hC6, 'h00);
    send_ops(vals, 0, 17, 1);
    idle(4);
    expect_sample("rhythm", 16000);
    bus.ryt = 1'b0;
  endtask

  task automatic test_saturation();
    int hi[18] = '{default: 4095};
    int lo[18] = '{default: -4096};
    for (int a = 'hC0; a <= 'hC8; a++) write_reg(a, 1);
    send_ops(hi, 0, 17, 1);
    idle(4);
    expect_sample("sat_pos", 32767);
    send_ops(lo, 0, 17, 1);
    idle(4);
    expect_sample("sat_neg", -32768);
    for (int a = 'hC0; a <= 'hC8; a++) write_reg(a, 0);
  endtask

  task automatic test_incomplete();
    int vals[18] = '{default: 0};
    int fe0;
    int sv0;
    vals[3] = 100;
    fe0 = fe_seen;
    sv0 = sv_seen;
    send_ops(vals, 5, 17, 1);
    idle(4);
    checks++;
    if (fe_seen - fe0 != 1 || sv_seen != sv0) begin
      errors++;
      $display("FAIL incomplete_strobes: fe=%0d sv=%0d expected fe=1 sv=0", fe_seen - fe0, sv_seen - sv0);
    end
    expect_sample("incomplete_hold", -32768);
    send_ops(vals, 0, 8, 1);
    apply_reset(2);
    fe0 = fe_seen;
    send_ops(vals, 9, 17, 1);
    idle(4);
    checks++;
    if (fe_seen - fe0 != 1 || sv_seen != sv0) begin
      errors++;
      $display("FAIL reset_midframe_strobes: fe=%0d sv=%0d expected fe=1 sv=0", fe_seen - fe0, sv_seen - sv0);
    end
    expect_sample("reset_midframe_sample", 0);
    send_ops(vals, 0, 17, 1);
    idle(4);
    expect_sample("recover_after_error", 200);
  endtask

  task automatic test_restart();
    int junk[18] = '{default: 3000};
    int vals[18] = '{default: 0};
    int fe0;
    vals[4] = -250;
    fe0 = fe_seen;
    send_ops(junk, 0, 9, 1);
    send_ops(vals, 0, 17, 1);
    idle(4);
    checks++;
    if (fe_seen != fe0) begin
      errors++;
      $display("FAIL restart_no_error: frame_error count %0d expected 0", fe_seen - fe0);
    end
    expect_sample("restart", -500);
  endtask

  task automatic test_random();
    int vals[18];
    int n;
    for (int f = 0; f < 40; f++) begin
      bus.ryt = 1'($urandom);
      for (int k = 0; k < 18; k++) vals[k] = int'($urandom_range(8191)) - 4096;
      for (int k = 0; k < 18; k++) begin
        n = k;
        if (k != 0 && k != 17 && $urandom_range(15) == 0) n = int'($urandom_range(31, 18));
        if (f % 7 == 3 && k == 9) continue;
        if ($urandom_range(9) == 0) bus.ryt = 1'($urandom);
        drive(1'b1, n, vals[k], 1'($urandom_range(3) == 0),
              int'($urandom_range('hCA, 'hBE)), int'($urandom_range(255)));
        idle(int'($urandom_range(2)));
      end
      idle(4);
      expect_sample("random_frame", m_last);
    end
    bus.ryt = 1'b0;
  endtask

  task automatic test_back_to_back();
    int vals[18];
    int sv0;
    sv0 = sv_seen;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 18; k++) vals[k] = int'($urandom_range(8191)) - 4096;
      send_ops(vals, 0, 17, 0);
    end
    idle(5);
    checks++;
    if (sv_seen - sv0 != 3) begin
      errors++;
      $display("FAIL back_to_back_count: sample_valid pulses %0d expected 3", sv_seen - sv0);
    end
    expect_sample("back_to_back", m_last);
  endtask

  initial begin
    bus.operator_out = '0;
    bus.opl2_reg_wr  = '0;
    bus.ryt          = 1'b0;
    test_reset();
    test_basic_carrier();
    test_additive();
    test_rhythm();
    test_saturation();
    test_incomplete();
    test_restart();
    test_random();
    test_back_to_back();
    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/channel_mixer.md
# channel_mixer

Downstream consumer of the operator time-slot sequencer. Takes the serial stream of 18 operator outputs produced once per sample period and accumulates the audible ones per the channel connection (CNT) and rhythm-mode rules. It then scales and saturates the sum into one signed DAC sample. Each completed sample is presented with a single-cycle valid strobe to the output/DAC stage.

## Interface
Parameters:
- OP_OUT_WIDTH, 13: signed operator output width; matches the package constant.
- DAC_OUTPUT_WIDTH, 16: signed output sample width.
- GAIN_SHIFT, 1: left shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- opl2_reg_wr  in  opl2_reg_wr_t  register write bus (valid, address, data).
- ryt  in  1  rhythm mode enable.
- operator_out  in  operator_out_t  {valid, op_num[OP_NUM_WIDTH], op_out signed OP_OUT_WIDTH}.
- sample  out  DAC_OUTPUT_WIDTH signed  last completed mixed sample.
- sample_valid  out  1  one-cycle strobe when sample updates.
- frame_error  out  1  one-cycle strobe when an incomplete frame is discarded.

## Operation
- CNT shadow: cnt[8:0] register. On opl2_reg_wr.valid with address 0xC0–0xC8, cnt[address-0xC0] <= data[0]. Reset value 0.
- Operator mapping for op n (0–17): g = n mod 6; ch = (n/6)*3 + (n mod 3). g≥3 is the carrier and g<3 is the modulator.
- Contribution, ryt=0: a carrier always contributes op_out. A modulator contributes op_out if cnt[ch], else 0.
- Contribution, ryt=1:
  - Ops 0–11 follow the ryt=0 rule.
  - Ops 13, 14, 15, 16 and 17 always contribute 2*op_out.
  - Op 12 contributes 2*op_out if cnt[6], else 0.
- Stage A (decode): on operator_out.valid, register the contribution (sign-extended to ACC_W = OP_OUT_WIDTH+6), is_first (op_num==0) and is_last (op_num==17). cnt and ryt are sampled here.
- Stage B (accumulate):
  - is_first: acc <= contribution; count <= 1; armed <= 1.
  - Otherwise: acc <= acc + contribution; count <= count+1 (saturates at 31).
- Stage C (output), on the stage-B cycle of an is_last entry:
  - If armed and count==18 (after increment): sample <= sat(acc <<< GAIN_SHIFT) and sample_valid pulses.
  - Otherwise frame_error pulses and sample holds.
  - In both cases armed <= 0.
- sat(): clamp to [-2^(DAC_OUTPUT_WIDTH-1), 2^(DAC_OUTPUT_WIDTH-1)-1]. The shifted value is computed at ACC_W+GAIN_SHIFT bits, so no overflow occurs before the clamp.
- Opcodes outside 0–17 contribute 0 but still count.

## Timing
- Reset (async assert, sync-safe deassert): sample=0, sample_valid=0, frame_error=0, acc=0, count=0, armed=0, cnt=0.
- Latency: an op_num 17 valid at cycle t gives sample/sample_valid (or frame_error) visible at cycle t+3.
- Inputs may arrive back-to-back, one per cycle. The normal upstream cadence is every 2 cycles. No backpressure.
- Register write and operator valid in the same cycle: that operator uses the old cnt. Later operators use the new value.
- ryt change mid-frame applies per operator at its stage A.
- op_num 0 while already armed restarts the frame silently. The partial sum is discarded.
- reset_n asserted mid-frame: the pipeline is cleared. The following partial frame yields frame_error at its op 17 and no sample_valid.
- Outputs are never simultaneously strobed. sample is stable between strobes.

## Test plan
- Reset: hold reset_n=0 with random inputs. Require sample=0, sample_valid=0, frame_error=0. After release, no strobe until a full frame arrives.
- Basic carrier: cnt=0, ryt=0, all ops 0 except op3=100, full frame. Require sample=200 and sample_valid high exactly 3 cycles after op17 valid.
- Additive connection: write 0xC0=0x01, then send op0=50, op3=100, others 0. Require sample=300. Write 0xC0 in the same cycle as op0 valid: require sample=200.
- Rhythm: ryt=1, cnt[6]=0, op12=500, ops13/14/16/17=1000, others 0. Require acc=8000 and sample=16000.
- Saturation: ryt=0, cnt=0x1FF, all ops 4095. Require sample=32767. All ops -4096: require sample=-32768.
- Incomplete frame: start a frame at op5 with no op0. Require frame_error pulse 3 cycles after op17 and sample unchanged. Assert reset_n mid-frame and require the same. The next full frame produces correct sample_valid.
